// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default widths for the CPU run/halt/step controller.
package cpu_ctrl_pkg;

    localparam int unsigned DefPcW   = 12;
    localparam int unsigned DefStepW = 12;
    localparam int unsigned DefCntW  = 32;

    typedef enum logic [1:0] {
        OpRun   = 2'd0,
        OpStep  = 2'd1,
        OpSetBp = 2'd2,
        OpClrBp = 2'd3
    } run_op_e;

    typedef enum logic [1:0] {
        StRunning  = 2'd0,
        StStepping = 2'd1,
        StHalted   = 2'd2
    } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Debug/host command port: valid/ready handshake carrying an opcode and argument.
interface cpu_run_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned STEP_W = DefStepW
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    run_op_e           cmd_op;
    logic [STEP_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/cpu_run_ctrl_pc_breakpoint.sv
// Single PC breakpoint: address/enable register, next-PC comparator and skip-one flag.
module pc_breakpoint
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = DefPcW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_bp,
    input  logic            clr_bp,
    input  logic [PC_W-1:0] set_addr,
    input  logic            arm_skip,
    input  logic            cpu_en,
    input  logic [PC_W-1:0] pc_next,
    output logic            match
);

    logic [PC_W-1:0] bp_addr_q, bp_addr_d;
    logic            bp_en_q, bp_en_d;
    logic            skip_q, skip_d;

    always_comb begin
        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;
        skip_d    = skip_q;
        if (set_bp) begin
            bp_addr_d = set_addr;
            bp_en_d   = 1'b1;
        end else if (clr_bp) begin
            bp_en_d = 1'b0;
        end
        // Arming wins so a RUN accepted while already running still skips the next cycle.
        if (arm_skip) begin
            skip_d = 1'b1;
        end else if (cpu_en) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_addr_q <= '0;
            bp_en_q   <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            bp_addr_q <= bp_addr_d;
            bp_en_q   <= bp_en_d;
            skip_q    <= skip_d;
        end
    end

    assign match = cpu_en & bp_en_q & (pc_next == bp_addr_q) & ~skip_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller producing the pipeline-wide update enable.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W          = DefPcW,
    parameter int unsigned STEP_W        = DefStepW,
    parameter int unsigned CNT_W         = DefCntW,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    cpu_run_ctrl_if.slave    cmd,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc_next,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    run_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic              bp_hit_q, bp_hit_d;
    logic              accept, arm_skip, bp_match;

    // Outputs decode registered state only; no combinational input-to-enable path.
    assign cpu_en        = (state_q != StHalted);
    assign halted        = (state_q == StHalted);
    assign cmd.cmd_ready = (state_q != StStepping);
    assign bp_hit        = bp_hit_q;
    assign cycle_cnt     = cycle_cnt_q;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;

    pc_breakpoint #(
        .PC_W (PC_W)
    ) u_pc_breakpoint (
        .clk      (clk),
        .rst      (rst),
        .set_bp   (accept && (cmd.cmd_op == OpSetBp)),
        .clr_bp   (accept && (cmd.cmd_op == OpClrBp)),
        .set_addr (cmd.cmd_arg[PC_W-1:0]),
        .arm_skip (arm_skip),
        .cpu_en   (cpu_en),
        .pc_next  (pc_next),
        .match    (bp_match)
    );

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        bp_hit_d = bp_hit_q;
        arm_skip = 1'b0;
        if (halt_req) begin
            state_d  = StHalted;
            bp_hit_d = 1'b0;
        end else if (bp_match) begin
            state_d  = StHalted;
            bp_hit_d = 1'b1;
        end else if (state_q == StStepping) begin
            if (step_q <= STEP_W'(1)) begin
                state_d = StHalted;
            end
            step_d = step_q - STEP_W'(1);
        end else if (accept) begin
            unique case (cmd.cmd_op)
                OpRun: begin
                    state_d  = StRunning;
                    bp_hit_d = 1'b0;
                    arm_skip = 1'b1;
                end
                OpStep: begin
                    // STEP while running is consumed without effect.
                    if (state_q == StHalted) begin
                        state_d  = StStepping;
                        step_d   = (cmd.cmd_arg == '0) ? STEP_W'(1) : cmd.cmd_arg;
                        bp_hit_d = 1'b0;
                        arm_skip = 1'b1;
                    end
                end
                OpSetBp, OpClrBp: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= START_RUNNING ? StRunning : StHalted;
            step_q      <= '0;
            bp_hit_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            bp_hit_q <= bp_hit_d;
            if (cpu_en) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the 3-stage RV32 CPU. Drives the pipeline-wide enable that gates PC and stage-register updates, and accepts commands from a debug/host port: run, step N instructions, set and clear one PC breakpoint. Sits beside `CPU` at the top level, observes the next-PC value (`PC_input`), and counts enabled cycles for performance and bench checks.

## Interface
- `PC_W`, 12, width of PC / breakpoint address
- `STEP_W`, 12, width of step count argument
- `CNT_W`, 32, width of enabled-cycle counter
- `START_RUNNING`, 1, state after reset: 1 = RUNNING, 0 = HALTED

Ports:
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, command accepted when `cmd_valid & cmd_ready`
- `cmd_op` in 2, 0 RUN, 1 STEP, 2 SET_BP, 3 CLR_BP
- `cmd_arg` in `STEP_W`, step count (STEP) or breakpoint address (SET_BP, low `PC_W` bits)
- `halt_req` in 1, level; forces HALTED
- `pc_next` in `PC_W`, value the PC loads at the next enabled edge
- `cpu_en` out 1, pipeline/PC update enable
- `halted` out 1, state == HALTED
- `bp_hit` out 1, sticky: last halt caused by breakpoint
- `cycle_cnt` out `CNT_W`, count of cycles with `cpu_en` = 1

## Operation
- States: RUNNING, STEPPING, HALTED. `cpu_en` = state ∈ {RUNNING, STEPPING}; decoded from registered state only, no input-to-`cpu_en` path.
- `cmd_ready` = state != STEPPING (registered state only).
- Priority each edge: `rst` > `halt_req` > breakpoint > step exhaustion > accepted command.
- `halt_req`=1: next state HALTED from any state; `bp_hit` cleared. A command handshaking in the same cycle is consumed; SET_BP/CLR_BP still take effect, RUN/STEP are discarded.
- RUN (HALTED or RUNNING): next state RUNNING; clears `bp_hit`; arms skip-one.
- STEP (HALTED only; ignored but consumed in RUNNING): load step counter with `cmd_arg`, 0 treated as 1; next state STEPPING; clears `bp_hit`; arms skip-one.
- STEPPING: counter decrements each cycle; the cycle it reaches 1, next state HALTED. Exactly N enabled cycles.
- SET_BP: `bp_addr` <= `cmd_arg[PC_W-1:0]`, `bp_en` <= 1. CLR_BP: `bp_en` <= 0. Accepted in HALTED or RUNNING, no state change.
- Breakpoint: when `cpu_en` & `bp_en` & `pc_next == bp_addr` & !skip-one, next state HALTED, `bp_hit` <= 1. The enabled edge still occurs, so the CPU halts with PC = `bp_addr`, instruction at `bp_addr` fetched but not advanced.
- Skip-one: suppresses breakpoint match for the first enabled cycle after leaving HALTED, so RUN/STEP from a breakpoint makes progress. Cleared after that cycle.
- `cycle_cnt` increments on every edge where `cpu_en` = 1; wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state = RUNNING if `START_RUNNING` else HALTED; `cpu_en` = `START_RUNNING`; `halted` = !`START_RUNNING`; `cmd_ready` = 1; `bp_hit` = 0; `bp_en` = 0; `bp_addr` = 0; step counter = 0; skip-one = 0; `cycle_cnt` = 0.
- Command accepted at edge k: new state visible, `cpu_en` updated, after edge k (1-cycle latency).
- `halt_req` sampled at edge k: `cpu_en` = 0 from edge k onward; the edge k itself is still enabled if already RUNNING/STEPPING.
- STEP N from HALTED: `cpu_en` high for exactly N cycles, `halted` high again the cycle after the last.
- Reset mid-STEPPING: state returns to reset value immediately, step count lost.

## Structure
- Shared package `cpu_ctrl_pkg`: `run_op_e` (RUN/STEP/SET_BP/CLR_BP encodings), `run_state_e` enum, default widths.
- One sub-module: `pc_breakpoint` (bp address/enable register, comparator, skip-one flag). Step counter, cycle counter, and FSM stay in `cpu_run_ctrl`.

## Test plan
- Reset with `START_RUNNING`=0: `halted`=1, `cpu_en`=0, `cycle_cnt`=0; STEP arg 3 → `cpu_en` high exactly 3 cycles, `cycle_cnt`=3, `halted`=1.
- STEP arg 0 → exactly 1 enabled cycle; STEP issued while RUNNING → consumed, state stays RUNNING.
- SET_BP 0x010, RUN, drive `pc_next` 0x00C,0x010 → halt after the 0x010 edge, `bp_hit`=1; RUN again with `pc_next`=0x010 → no re-hit, continues running, `bp_hit`=0.
- STEP arg 5 with breakpoint matching on 2nd cycle → halts after 2 cycles, `bp_hit`=1, `cycle_cnt` +2.
- `halt_req` and `cmd_valid`(RUN) same cycle while RUNNING → HALTED, RUN discarded; with SET_BP 0x020 instead → HALTED and `bp_addr`=0x020.
- Assert `rst` mid-STEPPING (arg 100, after 10 cycles) → immediate reset values; preload `cycle_cnt` near 0xFFFF_FFFF via run → wraps to 0.
